conv_mul_acc_pipe: RTL and testbench

CONV_MUL_ACC_PIPE -- requirements
Module: conv_mul_acc_pipe

---
 rtl/conv_mul_acc_pipe.sv | 135 +++++++++++++
 tb/tb_conv_mul_acc_pipe.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_mul_acc_pipe.sv
// conv_mul_acc_pipe: pipelined signed multiply-accumulate with first/last framing.
//   Product of din0*din1 rides NUM_STAGE tag registers, then feeds an ACC_WIDTH
//   accumulator with a sticky overflow flag and a saturating beat counter. A
//   registered result stage presents dout/beat_cnt/ovf one edge after a last beat
//   is accumulated, so latency from acceptance to out_valid is NUM_STAGE+1.
//   Optional feature macro: CONV_MUL_ACC_SAT_EN (clamp instead of wrap on overflow).
module conv_mul_acc_pipe #(
    parameter int DIN0_WIDTH = 8,
    parameter int DIN1_WIDTH = 16,
    parameter int ACC_WIDTH  = 32,
    parameter int NUM_STAGE  = 3,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                         ap_clk,
    input  logic                         ap_rst_n,
    input  logic                         ce,
    input  logic                         in_valid,
    input  logic signed [DIN0_WIDTH-1:0] din0,
    input  logic signed [DIN1_WIDTH-1:0] din1,
    input  logic                         first,
    input  logic                         last,
    output logic                         out_valid,
    output logic signed [ACC_WIDTH-1:0]  dout,
    output logic        [CNT_WIDTH-1:0]  beat_cnt,
    output logic                         ovf
);

    localparam int PW = DIN0_WIDTH + DIN1_WIDTH;

    localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    // One pipeline slot: the product plus its framing tags.
    typedef struct packed {
        logic                 vld;
        logic                 first;
        logic                 last;
        logic signed [PW-1:0] prod;
    } tag_t;

    tag_t                        stg_in;
    tag_t                        stg_q [NUM_STAGE];
    tag_t                        acc_in;

    logic signed [ACC_WIDTH-1:0] acc_q;
    logic        [CNT_WIDTH-1:0] cnt_q;
    logic                        ovf_st;
    logic                        res_pend;

    logic signed [ACC_WIDTH-1:0] prod_ext;
    logic signed [ACC_WIDTH-1:0] sum;
    logic                        add_ovf;
    logic signed [ACC_WIDTH-1:0] acc_nxt;
    logic        [CNT_WIDTH-1:0] cnt_nxt;

    // Full-precision product of the incoming beat, tagged for the pipeline.
    always_comb begin
        stg_in       = '0;
        stg_in.vld   = in_valid;
        stg_in.first = first;
        stg_in.last  = last;
        stg_in.prod  = din0 * din1;
    end

    // Multiplier pipeline: every slot shifts together when ce is high.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            for (int i = 0; i < NUM_STAGE; i++) stg_q[i] <= '0;
        end else if (ce) begin
            stg_q[0] <= stg_in;
            for (int i = 1; i < NUM_STAGE; i++) stg_q[i] <= stg_q[i-1];
        end
    end

    assign acc_in = stg_q[NUM_STAGE-1];

    // Sign-extended add with two's-complement overflow detection and
    // optional clamping; the counter sticks at its maximum.
    always_comb begin
        prod_ext = ACC_WIDTH'($signed(acc_in.prod));
        sum      = acc_q + prod_ext;
        add_ovf  = (acc_q[ACC_WIDTH-1] == prod_ext[ACC_WIDTH-1]) &&
                   (sum[ACC_WIDTH-1]   != acc_q[ACC_WIDTH-1]);
        acc_nxt  = sum;
`ifdef CONV_MUL_ACC_SAT_EN
        if (add_ovf) acc_nxt = acc_q[ACC_WIDTH-1] ? ACC_MIN : ACC_MAX;
`endif
        cnt_nxt  = (&cnt_q) ? cnt_q : cnt_q + CNT_WIDTH'(1);
    end

    // Accumulator: first restarts, bubbles leave state alone, last flags a result.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            acc_q    <= '0;
            cnt_q    <= '0;
            ovf_st   <= 1'b0;
            res_pend <= 1'b0;
        end else if (ce) begin
            res_pend <= acc_in.vld & acc_in.last;
            if (acc_in.vld) begin
                if (acc_in.first) begin
                    acc_q  <= prod_ext;
                    cnt_q  <= CNT_WIDTH'(1);
                    ovf_st <= 1'b0;
                end else begin
                    acc_q  <= acc_nxt;
                    cnt_q  <= cnt_nxt;
                    ovf_st <= ovf_st | add_ovf;
                end
            end
        end
    end

    // Result stage: pulses out_valid and holds the last result otherwise.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            out_valid <= 1'b0;
            dout      <= '0;
            beat_cnt  <= '0;
            ovf       <= 1'b0;
        end else if (ce) begin
            out_valid <= res_pend;
            if (res_pend) begin
                dout     <= acc_q;
                beat_cnt <= cnt_q;
                ovf      <= ovf_st;
            end
        end
    end

    // Min limit is only referenced when clamping is compiled in.
    logic unused_min;
    assign unused_min = ^ACC_MIN;

endmodule

// File: tb/tb_conv_mul_acc_pipe.sv
// Bench for conv_mul_acc_pipe: three instances (default, ACC_WIDTH=24,
// NUM_STAGE=1/CNT_WIDTH=3) share one stimulus stream; a queue-based
// reference model predicts every result and its arrival cycle.
module tb_conv_mul_acc_pipe;

    localparam int NDUT = 3;
`ifdef CONV_MUL_ACC_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic ap_clk = 1'b0, ap_rst_n = 1'b0, ce = 1'b0, in_valid = 1'b0, first = 1'b0, last = 1'b0;
    logic signed [7:0]  din0 = '0;
    logic signed [15:0] din1 = '0;

    logic ov_a, ovf_a, ov_b, ovf_b, ov_c, ovf_c;
    logic signed [31:0] dout_a, dout_c;
    logic signed [23:0] dout_b;
    logic [15:0] cnt_a, cnt_b;
    logic [2:0]  cnt_c;

    conv_mul_acc_pipe u_a (.ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ce(ce), .in_valid(in_valid),
        .din0(din0), .din1(din1), .first(first), .last(last),
        .out_valid(ov_a), .dout(dout_a), .beat_cnt(cnt_a), .ovf(ovf_a));
    conv_mul_acc_pipe #(.ACC_WIDTH(24)) u_b (.ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ce(ce),
        .in_valid(in_valid), .din0(din0), .din1(din1), .first(first), .last(last),
        .out_valid(ov_b), .dout(dout_b), .beat_cnt(cnt_b), .ovf(ovf_b));
    conv_mul_acc_pipe #(.NUM_STAGE(1), .CNT_WIDTH(3)) u_c (.ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
        .ce(ce), .in_valid(in_valid), .din0(din0), .din1(din1), .first(first), .last(last),
        .out_valid(ov_c), .dout(dout_c), .beat_cnt(cnt_c), .ovf(ovf_c));

    always #5 ap_clk = ~ap_clk;

    int errors = 0, checks = 0;

    // Reference model state
    int     lat  [NDUT] = '{4, 4, 2};
    int     aw   [NDUT] = '{32, 24, 32};
    longint cmax [NDUT] = '{65535, 65535, 7};
    longint m_acc[NDUT], m_cnt[NDUT];
    bit     m_ovf[NDUT];
    longint q_d[NDUT][8], q_c[NDUT][8], q_due[NDUT][8];
    bit     q_o[NDUT][8];
    int     q_h[NDUT], q_n[NDUT];
    longint last_d[NDUT], last_c[NDUT];
    bit     last_o[NDUT], prev_ov[NDUT];
    int     dres[NDUT];
    longint cecnt = 0;
    longint c_log_d[16], c_log_t[16];
    int     c_log_n = 0;
    bit     mon_ce, mon_rst;

    task automatic chk(input string name, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < NDUT; i++) begin
            m_acc[i] = 0; m_cnt[i] = 0; m_ovf[i] = 0;
            q_h[i] = 0; q_n[i] = 0;
            last_d[i] = 0; last_c[i] = 0; last_o[i] = 0; prev_ov[i] = 0;
        end
    endtask

    // Beat applied at acceptance; result queued with its due ce-cycle.
    task automatic model_beat(input int id, input longint a, input longint b, input bit f, input bit l);
        longint p, s, hi, lo;
        int t;
        p  = a * b;
        hi = (longint'(1) <<< (aw[id] - 1)) - 1;
        lo = -hi - 1;
        if (f) begin
            m_acc[id] = p; m_cnt[id] = 1; m_ovf[id] = 0;
        end else begin
            s = m_acc[id] + p;
            if (s > hi || s < lo) begin
                m_ovf[id] = 1;
                if (SAT) s = (s > hi) ? hi : lo;
                else     s = (s > hi) ? s - 2 * (hi + 1) : s + 2 * (hi + 1);
            end
            m_acc[id] = s;
            if (m_cnt[id] < cmax[id]) m_cnt[id]++;
        end
        if (l) begin
            t = (q_h[id] + q_n[id]) % 8;
            q_d[id][t] = m_acc[id]; q_c[id][t] = m_cnt[id]; q_o[id][t] = m_ovf[id];
            q_due[id][t] = cecnt + lat[id];
            q_n[id]++;
        end
    endtask

    task automatic get_out(input int id, output bit ov, output longint d, output longint c, output bit o);
        case (id)
            0:       begin ov = ov_a; d = longint'(dout_a); c = longint'(cnt_a); o = ovf_a; end
            1:       begin ov = ov_b; d = longint'(dout_b); c = longint'(cnt_b); o = ovf_b; end
            default: begin ov = ov_c; d = longint'(dout_c); c = longint'(cnt_c); o = ovf_c; end
        endcase
    endtask

    task automatic check_dut(input int id, input bit rst, input bit ce_s);
        bit ov, o, e_ov, e_o;
        longint d, c, e_d, e_c;
        get_out(id, ov, d, c, o);
        if (rst && ce_s && ov) dres[id]++;
        if (rst && ce_s && ov && id == 2 && c_log_n < 16) begin
            c_log_d[c_log_n] = d; c_log_t[c_log_n] = cecnt; c_log_n++;
        end
        if (!rst) begin
            e_ov = 0; e_d = 0; e_c = 0; e_o = 0;
        end else if (!ce_s) begin
            e_ov = prev_ov[id]; e_d = last_d[id]; e_c = last_c[id]; e_o = last_o[id];
        end else if (q_n[id] > 0 && q_due[id][q_h[id]] == cecnt) begin
            e_ov = 1;
            last_d[id] = q_d[id][q_h[id]]; last_c[id] = q_c[id][q_h[id]]; last_o[id] = q_o[id][q_h[id]];
            e_d = last_d[id]; e_c = last_c[id]; e_o = last_o[id];
            q_h[id] = (q_h[id] + 1) % 8; q_n[id]--;
        end else begin
            e_ov = 0; e_d = last_d[id]; e_c = last_c[id]; e_o = last_o[id];
        end
        prev_ov[id] = e_ov;
        chk($sformatf("dut%0d out_valid @%0d", id, cecnt), longint'(ov), longint'(e_ov));
        chk($sformatf("dut%0d dout @%0d", id, cecnt), d, e_d);
        chk($sformatf("dut%0d beat_cnt @%0d", id, cecnt), c, e_c);
        chk($sformatf("dut%0d ovf @%0d", id, cecnt), longint'(o), longint'(e_o));
    endtask

    // Scoreboard: model advances on each ce edge, outputs compared 1ns later.
    always @(posedge ap_clk) begin
        mon_rst = ap_rst_n;
        mon_ce  = ce;
        if (mon_rst && mon_ce) begin
            cecnt++;
            if (in_valid)
                for (int id = 0; id < NDUT; id++)
                    model_beat(id, longint'(din0), longint'(din1), first, last);
        end
        #1;
        for (int id = 0; id < NDUT; id++) check_dut(id, mon_rst, mon_ce);
    end

    // In-flight beats vanish on reset.
    always @(negedge ap_rst_n) model_clear();

    task automatic drv(input bit c, input bit v, input longint a, input longint b, input bit f, input bit l);
        @(negedge ap_clk);
        ce = c; in_valid = v; din0 = a[7:0]; din1 = b[15:0]; first = f; last = l;
    endtask

    task automatic idle(input int n);
        repeat (n) drv(1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic pulse_reset();
        bit ov, o;
        longint d, c;
        @(negedge ap_clk);
        ap_rst_n = 1'b0; in_valid = 1'b0;
        #1;
        for (int id = 0; id < NDUT; id++) begin
            get_out(id, ov, d, c, o);
            chk($sformatf("reset dut%0d out_valid", id), longint'(ov), 0);
            chk($sformatf("reset dut%0d dout", id), d, 0);
            chk($sformatf("reset dut%0d beat_cnt", id), c, 0);
            chk($sformatf("reset dut%0d ovf", id), longint'(o), 0);
        end
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
    endtask

    typedef struct { longint a; longint b; longint exp; } vec_t;
    vec_t tbl[6];

    initial begin
        int lat_seen, hits, n0[NDUT];
        longint cap_d, cap_c, cap_o;
        logic signed [7:0]  ra;
        logic signed [15:0] rb;

        tbl[0] = '{-3, 1000, -3000};
        tbl[1] = '{127, 32767, 4161409};
        tbl[2] = '{-128, -32768, 4194304};
        tbl[3] = '{-128, 32767, -4194176};
        tbl[4] = '{0, -32768, 0};
        tbl[5] = '{-1, -1, 1};

        model_clear();
        #2;
        chk("por out_valid", longint'(ov_a), 0);
        chk("por dout", longint'(dout_a), 0);
        chk("por beat_cnt", longint'(cnt_a), 0);
        chk("por ovf", longint'(ovf_a), 0);
        @(negedge ap_clk); @(negedge ap_clk);
        ap_rst_n = 1'b1; ce = 1'b1;
        idle(2);

        // Single first+last beats: latency and value from the table
        for (int v = 0; v < 6; v++) begin
            drv(1'b1, 1'b1, tbl[v].a, tbl[v].b, 1'b1, 1'b1);
            @(posedge ap_clk); #2;
            in_valid = 1'b0; first = 1'b0; last = 1'b0;
            lat_seen = 0; hits = 0; cap_d = 0; cap_c = 0; cap_o = 0;
            for (int k = 1; k <= 8; k++) begin
                @(posedge ap_clk); #2;
                if (ov_a) begin
                    hits++;
                    if (lat_seen == 0) begin
                        lat_seen = k; cap_d = longint'(dout_a); cap_c = longint'(cnt_a); cap_o = longint'(ovf_a);
                    end
                end
            end
            chk($sformatf("vec%0d latency", v), lat_seen, 4);
            chk($sformatf("vec%0d pulses", v), hits, 1);
            chk($sformatf("vec%0d dout", v), cap_d, tbl[v].exp);
            chk($sformatf("vec%0d beat_cnt", v), cap_c, 1);
            chk($sformatf("vec%0d ovf", v), cap_o, 0);
        end

        // Four beats with bubbles and ce gaps (ce=0 beat must be ignored)
        n0[0] = dres[0];
        drv(1, 1, 127, 32767, 1, 0);
        drv(1, 0, 0, 0, 0, 0);
        drv(0, 1, 5, 5, 0, 1);
        drv(1, 1, 127, 32767, 0, 0);
        drv(0, 0, 0, 0, 0, 0);
        drv(0, 0, 0, 0, 0, 0);
        drv(1, 1, 127, 32767, 0, 0);
        drv(1, 0, 0, 0, 0, 0);
        drv(0, 1, 127, 32767, 0, 1);
        drv(1, 1, 127, 32767, 0, 1);
        idle(8);
        chk("gap results", dres[0] - n0[0], 1);
        chk("gap dout", longint'(dout_a), 16645636);
        chk("gap beat_cnt", longint'(cnt_a), 4);

        // Overflow on the 24-bit instance, then a clean restart
        for (int k = 0; k < 3; k++) drv(1, 1, 127, 32767, k == 0, k == 2);
        idle(8);
        chk("ovf24 dout", longint'(dout_b), SAT ? 8388607 : -4292989);
        chk("ovf24 ovf", longint'(ovf_b), 1);
        chk("ovf32 dout", longint'(dout_a), 12484227);
        chk("ovf32 ovf", longint'(ovf_a), 0);
        drv(1, 1, 1, 1, 1, 1);
        idle(8);
        chk("restart24 dout", longint'(dout_b), 1);
        chk("restart24 ovf", longint'(ovf_b), 0);

        // Continuation after last keeps the accumulator
        drv(1, 1, 2, 3, 0, 1);
        idle(8);
        chk("continue dout", longint'(dout_a), 7);
        chk("continue beat_cnt", longint'(cnt_a), 2);

        // Reset with beats in flight: no result, then fresh beat
        for (int id = 0; id < NDUT; id++) n0[id] = dres[id];
        for (int k = 0; k < 4; k++) drv(1, 1, 3, 3, k == 0, k == 3);
        pulse_reset();
        idle(8);
        for (int id = 0; id < NDUT; id++)
            chk($sformatf("flush dut%0d results", id), dres[id] - n0[id], 0);
        drv(1, 1, 2, -5, 1, 1);
        idle(8);
        chk("post-reset dout", longint'(dout_a), -10);
        chk("post-reset results", dres[0] - n0[0], 1);

        // Back-to-back single-beat results on NUM_STAGE=1
        idle(2);
        c_log_n = 0;
        drv(1, 1, 1, 1, 1, 1);
        drv(1, 1, 2, 2, 1, 1);
        drv(1, 1, -1, 4, 1, 1);
        idle(6);
        chk("b2b count", c_log_n, 3);
        chk("b2b r0", c_log_d[0], 1);
        chk("b2b r1", c_log_d[1], 4);
        chk("b2b r2", c_log_d[2], -4);
        chk("b2b spacing01", c_log_t[1] - c_log_t[0], 1);
        chk("b2b spacing12", c_log_t[2] - c_log_t[1], 1);

        // Counter saturation on the 3-bit counter instance
        for (int k = 0; k < 10; k++) drv(1, 1, 1, 1, k == 0, k == 9);
        idle(6);
        chk("sat cnt3", longint'(cnt_c), 7);
        chk("sat dout", longint'(dout_c), 10);
        chk("cnt16", longint'(cnt_a), 10);

        // Random traffic against the scoreboard
        for (int k = 0; k < 600; k++) begin
            if (k == 300) pulse_reset();
            ra = 8'($urandom);
            rb = 16'($urandom);
            drv($urandom_range(0, 9) != 0, $urandom_range(0, 9) < 7, longint'(ra), longint'(rb),
                $urandom_range(0, 4) == 0, $urandom_range(0, 3) == 0);
        end
        idle(8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
